// File: rtl/stream_mux_rr_pkg.sv
// Shared types and constants for the stream_mux_rr N:1 stream multiplexer.
package mux_pkg;

  typedef enum logic {MODE_SEL = 1'b0, MODE_RR = 1'b1} mux_mode_t;
  typedef enum logic {EMPTY, FULL} mux_state_t;

  localparam int CNT_W = 16;

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, wrapping.
module rr_arbiter #(
  parameter  int NCH  = 4,
  localparam int SELW = $clog2(NCH)
) (
  input  logic [NCH-1:0]  req,
  input  logic [SELW-1:0] ptr,
  input  logic            en,
  output logic            gnt_vld,
  output logic [SELW-1:0] gnt_idx
);

  // Constant bit indices only; the offset loop walks the wrap-around order.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int off = 0; off < NCH; off++) begin
      for (int k = 0; k < NCH; k++) begin
        if (en && !gnt_vld && req[k] && (k == ((int'(ptr) + off) % NCH))) begin
          gnt_vld = 1'b1;
          gnt_idx = SELW'(k);
        end
      end
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N:1 valid/ready stream mux with registered output, select or round-robin mode.
// Optional per-channel saturating grant counters under `MUX_GRANT_CNT_EN.
module stream_mux_rr
  import mux_pkg::*;
#(
  parameter  int NCH   = 4,
  parameter  int WIDTH = 8,
  localparam int SELW  = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  input  logic [NCH-1:0]       in_valid,
  input  logic [NCH*WIDTH-1:0] in_data,
  output logic [NCH-1:0]       in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_ch,
`ifdef MUX_GRANT_CNT_EN
  output logic [NCH*CNT_W-1:0] grant_cnt,
`endif
  input  logic                 out_ready
);

  mux_state_t       r_state;
  logic [WIDTH-1:0] r_data;
  logic [SELW-1:0]  r_ch;
  logic [SELW-1:0]  r_ptr;

  logic             w_ld;
  logic             w_rr;
  logic             w_sel_vld;
  logic             w_arb_vld;
  logic [SELW-1:0]  w_arb_idx;
  logic             w_gnt_vld;
  logic [SELW-1:0]  w_gnt_idx;
  logic [WIDTH-1:0] w_gnt_data;
  logic [SELW-1:0]  w_ptr_nxt;

  assign w_ld = (r_state == EMPTY) || out_ready;
  assign w_rr = (mux_mode_t'(mode) == MODE_RR);

  rr_arbiter #(.NCH(NCH)) u_arb (
    .req     (in_valid),
    .ptr     (r_ptr),
    .en      (w_ld),
    .gnt_vld (w_arb_vld),
    .gnt_idx (w_arb_idx)
  );

  // A sel at or beyond NCH matches no k, so it never grants.
  always_comb begin
    w_sel_vld = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      if (sel == SELW'(k)) w_sel_vld = in_valid[k];
    end
  end

  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    if (w_rr) begin
      w_gnt_vld = w_arb_vld;
      w_gnt_idx = w_arb_idx;
    end else if (w_ld && w_sel_vld) begin
      w_gnt_vld = 1'b1;
      w_gnt_idx = sel;
    end
  end

  always_comb begin
    in_ready   = '0;
    w_gnt_data = '0;
    for (int k = 0; k < NCH; k++) begin
      if (w_gnt_vld && (w_gnt_idx == SELW'(k))) begin
        in_ready[k] = 1'b1;
        w_gnt_data  = in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  assign w_ptr_nxt = (w_gnt_idx == SELW'(NCH - 1)) ? '0 : w_gnt_idx + SELW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
      r_data  <= '0;
      r_ch    <= '0;
      r_ptr   <= '0;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_gnt_vld) begin
            r_state <= FULL;
            r_data  <= w_gnt_data;
            r_ch    <= w_gnt_idx;
          end
        end
        FULL: begin
          if (out_ready) begin
            if (w_gnt_vld) begin
              r_data <= w_gnt_data;
              r_ch   <= w_gnt_idx;
            end else begin
              r_state <= EMPTY;
            end
          end
        end
        default: r_state <= EMPTY;
      endcase
      if (w_gnt_vld && w_rr) r_ptr <= w_ptr_nxt;
    end
  end

  assign out_valid = (r_state == FULL);
  assign out_data  = r_data;
  assign out_ch    = r_ch;

`ifdef MUX_GRANT_CNT_EN
  logic [CNT_W-1:0] r_cnt [NCH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NCH; k++) r_cnt[k] <= '0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (w_gnt_vld && (w_gnt_idx == SELW'(k)) && (r_cnt[k] != {CNT_W{1'b1}}))
          r_cnt[k] <= r_cnt[k] + CNT_W'(1);
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NCH; k++) grant_cnt[k*CNT_W +: CNT_W] = r_cnt[k];
  end
`endif

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: a 4-channel and a 5-channel instance.
module tb_stream_mux_rr;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        mode = 1'b0;
  logic [1:0]  sel = '0;
  logic [3:0]  in_valid = '0;
  logic [31:0] in_data = '0;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_ch;
  logic        out_ready = 1'b1;

  logic        mode5 = 1'b0;
  logic [2:0]  sel5 = '0;
  logic [4:0]  in_valid5 = '0;
  logic [39:0] in_data5 = '0;
  logic [4:0]  in_ready5;
  logic        out_valid5;
  logic [7:0]  out_data5;
  logic [2:0]  out_ch5;
  logic        out_ready5 = 1'b1;

`ifdef MUX_GRANT_CNT_EN
  logic [63:0] grant_cnt;
  logic [79:0] grant_cnt5;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  stream_mux_rr #(.NCH(4), .WIDTH(8)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ch    (out_ch),
`ifdef MUX_GRANT_CNT_EN
    .grant_cnt (grant_cnt),
`endif
    .out_ready (out_ready)
  );

  stream_mux_rr #(.NCH(5), .WIDTH(8)) u_dut5 (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode5),
    .sel       (sel5),
    .in_valid  (in_valid5),
    .in_data   (in_data5),
    .in_ready  (in_ready5),
    .out_valid (out_valid5),
    .out_data  (out_data5),
    .out_ch    (out_ch5),
`ifdef MUX_GRANT_CNT_EN
    .grant_cnt (grant_cnt5),
`endif
    .out_ready (out_ready5)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] exp_rdy [4];
    logic [1:0] exp_ch  [4];

    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'h00);
    chk("rst_out_ch",    32'(out_ch),    32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd0);
    step();
    rst_n = 1'b1;
    step();

    // mode 0 directed select
    mode = 1'b0; sel = 2'd2; in_valid = 4'b0100; in_data[2*8 +: 8] = 8'hA5;
    #1;
    chk("m0_in_ready", 32'(in_ready), 32'b0100);
    step();
    chk("m0_out_valid", 32'(out_valid), 32'd1);
    chk("m0_out_data",  32'(out_data),  32'hA5);
    chk("m0_out_ch",    32'(out_ch),    32'd2);
    in_valid = '0;
    step();
    chk("m0_drain_valid", 32'(out_valid), 32'd0);
    chk("m0_drain_hold",  32'(out_data),  32'hA5);

    // round-robin, all channels valid
    mode = 1'b1;
    for (int k = 0; k < 4; k++) in_data[k*8 +: 8] = 8'h10 + 8'(k);
    in_valid = 4'b1111;
    #1;
    chk("rr_first_rdy", 32'(in_ready), 32'b0001);
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("rr_all_ch%0d", i),   32'(out_ch),    32'(i % 4));
      chk($sformatf("rr_all_vld%0d", i),  32'(out_valid), 32'd1);
      chk($sformatf("rr_all_data%0d", i), 32'(out_data),  32'h10 + 32'(i % 4));
    end
    in_valid = '0;
    step();
    chk("rr_all_drain", 32'(out_valid), 32'd0);

    // round-robin, sparse requesters 1 and 3
    exp_rdy = '{4'b0010, 4'b1000, 4'b0010, 4'b1000};
    exp_ch  = '{2'd1, 2'd3, 2'd1, 2'd3};
    in_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("rr_sp_rdy%0d", i), 32'(in_ready), 32'(exp_rdy[i]));
      step();
      chk($sformatf("rr_sp_ch%0d", i),  32'(out_ch),   32'(exp_ch[i]));
    end
    in_valid = '0;
    step();

    // backpressure hold, then back-to-back reload
    mode = 1'b0; sel = 2'd0; in_valid = 4'b0001; in_data[0 +: 8] = 8'h3C;
    step();
    chk("bp_load", 32'(out_data), 32'h3C);
    out_ready = 1'b0; sel = 2'd1; in_valid = 4'b0011; in_data[8 +: 8] = 8'h5A;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("bp_rdy%0d", i),  32'(in_ready),  32'd0);
      step();
      chk($sformatf("bp_data%0d", i), 32'(out_data),  32'h3C);
      chk($sformatf("bp_vld%0d", i),  32'(out_valid), 32'd1);
      chk($sformatf("bp_ch%0d", i),   32'(out_ch),    32'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_rdy", 32'(in_ready), 32'b0010);
    step();
    chk("bp_next_data", 32'(out_data),  32'h5A);
    chk("bp_next_ch",   32'(out_ch),    32'd1);
    chk("bp_next_vld",  32'(out_valid), 32'd1);
    in_valid = '0;
    step();

    // 5-channel instance: out-of-range select never grants
    mode5 = 1'b0; sel5 = 3'd5; in_valid5 = 5'b11111;
    for (int k = 0; k < 5; k++) in_data5[k*8 +: 8] = 8'hC0 + 8'(k);
    #1;
    chk("n5_oor_rdy", 32'(in_ready5), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("n5_oor_vld%0d", i), 32'(out_valid5), 32'd0);
    end
    sel5 = 3'd4;
    #1;
    chk("n5_last_rdy", 32'(in_ready5), 32'b10000);
    step();
    chk("n5_last_ch",   32'(out_ch5),   32'd4);
    chk("n5_last_data", 32'(out_data5), 32'hC4);
    in_valid5 = '0;

    // reset while FULL, mode 1 restarts at channel 0
    mode = 1'b1; in_valid = 4'b1111;
    step();
    step();
    chk("mid_full", 32'(out_ch), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_vld",  32'(out_valid), 32'd0);
    chk("mid_rst_data", 32'(out_data),  32'h00);
    #2;
    rst_n = 1'b1;
    #1;
    chk("mid_rst_rdy", 32'(in_ready), 32'b0001);
    step();
    chk("mid_rst_ch0", 32'(out_ch), 32'd0);
    in_valid = '0;
    step();

`ifdef MUX_GRANT_CNT_EN
    rst_n = 1'b0;
    #1;
    chk("cnt_rst", 32'(grant_cnt[16 +: 16]), 32'd0);
    rst_n = 1'b1;
    mode = 1'b0; sel = 2'd1; in_valid = 4'b0010;
    repeat (100) step();
    chk("cnt_100", 32'(grant_cnt[16 +: 16]), 32'd100);
    repeat (69900) step();
    chk("cnt_sat",   32'(grant_cnt[16 +: 16]), 32'hFFFF);
    chk("cnt_ch0",   32'(grant_cnt[0 +: 16]),  32'd0);
    repeat (5) step();
    chk("cnt_stays", 32'(grant_cnt[16 +: 16]), 32'hFFFF);
    in_valid = '0;
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
